truth_table_checker: RTL and testbench

Sequential stimulus-and-check stage wrapped around a 2-input combinational gate block (e.g. the `~(~a&b)` NAND-built function). On a start request it drives the gate's `a`/`b` inputs through all four combinations in order, waits a fixed settle time per row, samples the gate's `s` output, and compares it against a parameterised expected truth table. It sits directly upstream and downstream of the gate: it feeds `a`/`b` and consumes `s`, replacing the hand-written `initial`/`$monitor` test sequence with a synthesizable checker.

---
 rtl/truth_table_pkg.sv | 16 +
 rtl/settle_counter.sv | 32 +++
 rtl/truth_table_checker.sv | 123 ++++++++++++
 tb/tb_truth_table_checker.sv | 133 +++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table checker.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int TT_ROWS  = 4;
  localparam int TT_ROW_W = 2;
  localparam int TT_CNT_W = 4;
  localparam logic [TT_ROWS-1:0] TT_DEFAULT_EXPECTED = 4'b1101;

endpackage

// File: rtl/settle_counter.sv
// Settle-time up-counter; o_tc flags the last settle cycle (count == SETTLE_CYCLES-1).
module settle_counter
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  output logic [TT_CNT_W-1:0] o_cnt,
  output logic                o_tc
);

  localparam logic [TT_CNT_W-1:0] TC_VAL = TT_CNT_W'(SETTLE_CYCLES - 1);

  logic [TT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/truth_table_checker.sv
// Drives a 2-input gate through rows 00..11, samples s_in after a settle time and scores it
// against EXPECTED. Define TT_CHECKER_LOG_EN for per-row and summary simulation logging.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | row driven, waiting SETTLE_CYCLES for the gate output
// SAMPLE | compare s_in with EXPECTED[row], advance or finish
// DONE   | results and a/b=11 held until start or reset
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [TT_ROWS-1:0] EXPECTED      = TT_DEFAULT_EXPECTED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_in,
  output logic               a_out,
  output logic               b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_count,
  output logic [TT_ROWS-1:0] fail_mask
);

  tt_state_e             r_state, w_state_nxt;
  logic [TT_ROW_W-1:0]   r_row, w_row_nxt;
  logic [1:0]            r_ab, w_ab_nxt;
  logic [2:0]            r_err, w_err_nxt;
  logic [TT_ROWS-1:0]    r_mask, w_mask_nxt;
  logic                  w_cnt_clr, w_cnt_en, w_tc, w_mismatch;
  logic [TT_CNT_W-1:0]   w_cnt;

  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_ab    <= '0;
      r_err   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_ab    <= w_ab_nxt;
      r_err   <= w_err_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_ab_nxt    = r_ab;
    w_err_nxt   = r_err;
    w_mask_nxt  = r_mask;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_mismatch  = (s_in != EXPECTED[r_row]);
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_row_nxt   = '0;
          w_ab_nxt    = 2'b00;
          w_err_nxt   = '0;
          w_mask_nxt  = '0;
          w_cnt_clr   = 1'b1;
        end
      end
      SETTLE: begin
        w_cnt_en = 1'b1;
        if (w_tc) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (w_mismatch) begin
          w_err_nxt         = r_err + 1'b1;
          w_mask_nxt[r_row] = 1'b1;
        end
        if (r_row == TT_ROW_W'(TT_ROWS - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_row_nxt   = r_row + 1'b1;
          w_ab_nxt    = r_row + 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef TT_CHECKER_LOG_EN
  always @(posedge clk) begin
    if (rst_n && r_state == SAMPLE) begin
      $display("tt_checker row=%0d a=%b b=%b s_in=%b exp=%b %s cnt=%0d",
               r_row, r_ab[1], r_ab[0], s_in, EXPECTED[r_row],
               w_mismatch ? "FAIL" : "OK", w_cnt);
      if (r_row == TT_ROW_W'(TT_ROWS - 1))
        $display("tt_checker done err_count=%0d fail_mask=%b", w_err_nxt, w_mask_nxt);
    end
  end
`endif

  assign a_out     = r_ab[1];
  assign b_out     = r_ab[0];
  assign busy      = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign pass      = done && (r_err == 3'd0);
  assign err_count = r_err;
  assign fail_mask = r_mask;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checkers (settle 2 and 1) around modelled gates, compared per cycle
// against an arithmetic model of row timing and mismatch scoring.
module tb_truth_table_checker;

  localparam logic [3:0] EXP_TT = 4'b1101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic       gate0 = 1'b1, gate1 = 1'b1;
  logic [3:0] tbl0 = 4'b0, tbl1 = 4'b0;
  logic       s0, s1;
  logic       a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  int n_assert = 0;
  int n_fail = 0;

  // External gate under check: real ~(~a&b) function, or an arbitrary faulty table.
  assign s0 = gate0 ? ~(~a0 & b0) : tbl0[{a0, b0}];
  assign s1 = gate1 ? ~(~a1 & b1) : tbl1[{a1, b1}];

  truth_table_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .s_in(s0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0)
  );

  truth_table_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_in(s1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  function automatic logic [11:0] obs(input bit sel);
    if (sel) return {a1, b1, busy1, done1, pass1, err1, mask1};
    return {a0, b0, busy0, done0, pass0, err0, mask0};
  endfunction

  function automatic int popcount(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed={ab,busy,done,pass,err,mask}=%b expected=%b", tag, o, e);
    end
  endtask

  // k counts edges after the accepting edge (k=0). stop_at>0 abandons the run after that edge.
  task automatic run(input bit sel, input bit use_gate, input logic [3:0] tbl,
                     input int again, input int stop_at);
    int          per = sel ? 2 : 3;
    int          n_edges = 4 * per;
    logic [3:0]  gate_tt = use_gate ? EXP_TT : tbl;
    logic [3:0]  mis = gate_tt ^ EXP_TT;
    logic [11:0] e;
    if (sel) begin gate1 = use_gate; tbl1 = tbl; end
    else     begin gate0 = use_gate; tbl0 = tbl; end
    for (int k = 0; k <= n_edges; k++) begin
      int         rows_done, mk, row;
      logic       dn;
      logic [3:0] m;
      if (stop_at > 0 && k > stop_at) break;
      if (sel) start1 = (k == 0 || k == again);
      else     start0 = (k == 0 || k == again);
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      dn        = (k == n_edges);
      rows_done = k / per;
      row       = dn ? 3 : rows_done;
      mk        = (1 << rows_done) - 1;
      m         = mis & mk[3:0];
      e = {row[1:0], ~dn, dn, dn && popcount(m) == 0, 3'(popcount(m)), m};
      chk($sformatf("sel%0d tbl%b k%0d", sel, gate_tt, k), obs(sel), e);
    end
    if (stop_at == 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("sel%0d hold", sel), obs(sel),
          {2'b11, 1'b0, 1'b1, mis == 4'b0, 3'(popcount(mis)), mis});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset0", obs(0), 12'h000);
    chk("reset1", obs(1), 12'h000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle0", obs(0), 12'h000);

    run(0, 1, 4'b0000, 0, 0);   // correct gate
    run(0, 0, 4'b0000, 0, 0);   // s_in tied 0
    run(0, 0, 4'b1111, 0, 0);   // s_in tied 1
    run(0, 1, 4'b0000, 5, 0);   // correct gate after failure, start re-pulsed mid-run

    run(0, 0, 4'b0000, 0, 6);   // reset mid-run
    rst_n = 1'b0;
    #1;
    chk("midreset0", obs(0), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset0", obs(0), 12'h000);
    run(0, 1, 4'b0000, 0, 0);

    run(1, 1, 4'b0000, 0, 0);   // settle 1: done after 8
    run(1, 0, 4'b0000, 0, 0);

    for (int i = 0; i < 8; i++) begin
      bit         sel = 1'($urandom_range(0, 1));
      logic [3:0] t = 4'($urandom);
      int         ag = int'($urandom_range(1, sel ? 8 : 12));
      run(sel, 0, t, ag, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
